// File: rtl/xnor_lock_detector_if.sv
// Sample/result bundle for xnor_lock_detector: A/B words in, registered
// agreement terms and lock status out.
interface xnor_lock_detector_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    localparam int MB_W = $clog2(WIDTH + 1);

    logic             valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             valid_out;
    logic [WIDTH-1:0] f;
    logic [MB_W-1:0]  match_bits;
    logic             equal;
    logic [CNT_W-1:0] run_cnt;
    logic             locked;

    modport master (
        output valid, A, B,
        input  valid_out, f, match_bits, equal, run_cnt, locked
    );

    modport slave (
        input  valid, A, B,
        output valid_out, f, match_bits, equal, run_cnt, locked
    );
endinterface

// File: rtl/xnor_lock_detector.sv
// Registered XNOR/popcount of two words plus a run-length lock FSM.
// Define XNOR_LOCK_TOLERANCE_EN to add a HOLD state that forgives one isolated mismatch.
module xnor_lock_detector #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    xnor_lock_detector_if.slave  bus
);
    localparam int MB_W = $clog2(WIDTH + 1);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] COUNT  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
`ifdef XNOR_LOCK_TOLERANCE_EN
    localparam logic [1:0] HOLD   = 2'd3;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [MB_W-1:0]  mb_q, mb_d;
    logic             eq_q, eq_d;
    logic             vld_q;

    logic [WIDTH-1:0] x;
    logic             eq;
    logic [MB_W-1:0]  pop;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        x   = ~(bus.A ^ bus.B);
        eq  = &x;
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + MB_W'(x[i]);
        end
    end

    assign cnt_inc = run_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        f_d       = f_q;
        mb_d      = mb_q;
        eq_d      = eq_q;
        if (bus.valid) begin
            f_d  = x;
            mb_d = pop;
            eq_d = eq;
            case (state_q)
                SEARCH: begin
                    if (eq) begin
                        run_cnt_d = CNT_W'(1);
                        state_d   = (LOCK_COUNT == 1) ? LOCKED : COUNT;
                    end else begin
                        run_cnt_d = '0;
                    end
                end
                COUNT: begin
                    if (eq) begin
                        run_cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(LOCK_COUNT)) state_d = LOCKED;
                    end else begin
                        run_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
                LOCKED: begin
                    if (eq) begin
                        // Saturate rather than wrap so a long lock never looks like a fresh run
                        if (run_cnt_q != '1) run_cnt_d = cnt_inc;
                    end else begin
                        run_cnt_d = '0;
`ifdef XNOR_LOCK_TOLERANCE_EN
                        state_d   = HOLD;
`else
                        state_d   = SEARCH;
`endif
                    end
                end
`ifdef XNOR_LOCK_TOLERANCE_EN
                HOLD: begin
                    if (eq) begin
                        run_cnt_d = CNT_W'(1);
                        state_d   = LOCKED;
                    end else begin
                        run_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
`endif
                default: begin
                    run_cnt_d = '0;
                    state_d   = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEARCH;
            run_cnt_q <= '0;
            f_q       <= '0;
            mb_q      <= '0;
            eq_q      <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            f_q       <= f_d;
            mb_q      <= mb_d;
            eq_q      <= eq_d;
            vld_q     <= bus.valid;
        end
    end

    assign bus.valid_out  = vld_q;
    assign bus.f          = f_q;
    assign bus.match_bits = mb_q;
    assign bus.equal      = eq_q;
    assign bus.run_cnt    = run_cnt_q;
`ifdef XNOR_LOCK_TOLERANCE_EN
    assign bus.locked     = (state_q == LOCKED) || (state_q == HOLD);
`else
    assign bus.locked     = (state_q == LOCKED);
`endif
endmodule

// File: tb/tb_xnor_lock_detector.sv
// Directed bench for xnor_lock_detector (WIDTH=8, LOCK_COUNT=4, CNT_W=4).
module tb_xnor_lock_detector;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    xnor_lock_detector_if #(.WIDTH(8), .CNT_W(4)) bus ();

    xnor_lock_detector #(.WIDTH(8), .LOCK_COUNT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Present one sample across a rising edge; outputs are sampled 1 time unit later.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
        @(negedge clk);
        bus.valid = v;
        bus.A     = a;
        bus.B     = b;
        rst       = r;
        @(posedge clk);
        #1;
        rst       = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic vo, input logic [7:0] f,
                           input logic [3:0] mb, input logic eq, input logic [3:0] rc,
                           input logic lk);
        chk({tag, ".valid_out"},  32'(bus.valid_out),  32'(vo));
        chk({tag, ".f"},          32'(bus.f),          32'(f));
        chk({tag, ".match_bits"}, 32'(bus.match_bits), 32'(mb));
        chk({tag, ".equal"},      32'(bus.equal),      32'(eq));
        chk({tag, ".run_cnt"},    32'(bus.run_cnt),    32'(rc));
        chk({tag, ".locked"},     32'(bus.locked),     32'(lk));
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        // Reset: all outputs zero
        step(1'b1, 8'hA5, 8'hA5, 1'b1);
        chk_all("reset", 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0);

        // Four equal samples lock on the 4th edge
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'hA5, 8'hA5, 1'b0);
            chk_all($sformatf("eq_run%0d", i), 1'b1, 8'hFF, 4'd8, 1'b1, 4'(i), (i == 4));
        end

        // Fully-different words from reset
        step(1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b1, 8'hF0, 8'h0F, 1'b0);
        chk_all("all_diff", 1'b1, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0);

        // Three equal, 5-cycle gap holds everything, then 4th equal locks
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 8'h3C, 8'h3C, 1'b0);
            chk($sformatf("gap_pre%0d.run_cnt", i), 32'(bus.run_cnt), 32'(i));
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h12, 8'h34, 1'b0);
            chk_all($sformatf("gap%0d", i), 1'b0, 8'hFF, 4'd8, 1'b1, 4'd3, 1'b0);
        end
        step(1'b1, 8'h3C, 8'h3C, 1'b0);
        chk_all("gap_lock", 1'b1, 8'hFF, 4'd8, 1'b1, 4'd4, 1'b1);

        // Saturation at 15 without wrap
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 8'h77, 8'h77, 1'b0);
            chk($sformatf("sat%0d.run_cnt", i), 32'(bus.run_cnt), (4 + i > 15) ? 32'd15 : 32'(4 + i));
            chk($sformatf("sat%0d.locked", i), 32'(bus.locked), 32'd1);
        end

        // One mismatch (bit 0 differs: f=FE, 7 matching bits), then one equal sample
        step(1'b1, 8'h3C, 8'h3D, 1'b0);
`ifdef XNOR_LOCK_TOLERANCE_EN
        chk_all("miss1", 1'b1, 8'hFE, 4'd7, 1'b0, 4'd0, 1'b1);
`else
        chk_all("miss1", 1'b1, 8'hFE, 4'd7, 1'b0, 4'd0, 1'b0);
`endif
        step(1'b1, 8'h3C, 8'h3C, 1'b0);
`ifdef XNOR_LOCK_TOLERANCE_EN
        chk_all("recover", 1'b1, 8'hFF, 4'd8, 1'b1, 4'd1, 1'b1);
`else
        chk_all("recover", 1'b1, 8'hFF, 4'd8, 1'b1, 4'd1, 1'b0);
`endif
        // Two consecutive mismatches always drop lock
        step(1'b1, 8'h00, 8'h01, 1'b0);
`ifdef XNOR_LOCK_TOLERANCE_EN
        chk("miss2a.locked", 32'(bus.locked), 32'd1);
`else
        chk("miss2a.locked", 32'(bus.locked), 32'd0);
`endif
        step(1'b1, 8'h00, 8'h03, 1'b0);
        chk_all("miss2b", 1'b1, 8'hFC, 4'd6, 1'b0, 4'd0, 1'b0);

        // Reset coincident with the 3rd equal sample discards it
        step(1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b1, 8'h5A, 8'h5A, 1'b0);
        step(1'b1, 8'h5A, 8'h5A, 1'b0);
        chk("pre_rst.run_cnt", 32'(bus.run_cnt), 32'd2);
        step(1'b1, 8'h5A, 8'h5A, 1'b1);
        chk_all("mid_rst", 1'b0, 8'h00, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'h5A, 8'h5A, 1'b0);
            chk($sformatf("post_rst%0d.run_cnt", i), 32'(bus.run_cnt), 32'(i));
            chk($sformatf("post_rst%0d.locked", i), 32'(bus.locked), (i == 4) ? 32'd1 : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/xnor_lock_detector.md
# xnor_lock_detector

Parametrised successor to the two-input XNOR equality gate. Each valid cycle it registers the bitwise XNOR of two WIDTH-bit words and a popcount of matching bits. It also tracks a run of consecutive fully-equal samples and asserts `locked` once LOCK_COUNT equal samples arrive in a row. It sits downstream of data/reference word sources as a pattern-agreement and lock monitor.

## Interface
- `WIDTH`, 8, word width in bits; ≥1
- `LOCK_COUNT`, 4, consecutive equal samples required for lock; 1 ≤ LOCK_COUNT ≤ 2^CNT_W−1
- `CNT_W`, 8, width of the run counter
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `valid`  in  1  A/B sample valid this cycle
- `A`  in  WIDTH  word A
- `B`  in  WIDTH  word B
- `valid_out`  out  1  registered copy of `valid`
- `f`  out  WIDTH  registered bitwise XNOR of A and B, updated only on valid
- `match_bits`  out  $clog2(WIDTH+1)  number of 1s in `f`, updated only on valid
- `equal`  out  1  registered: last valid sample had A == B
- `run_cnt`  out  CNT_W  consecutive equal valid samples, saturating
- `locked`  out  1  high while FSM is in LOCKED

## Operation
- Per-sample terms: x = ~(A ^ B); eq = &x; pop = popcount(x), computed at WIDTH-exact width.
- FSM states: SEARCH (reset), COUNT, LOCKED. With the macro defined, a fourth state, HOLD, is added.
- Transitions are evaluated only when `valid`=1. When `valid`=0, state, `f`, `match_bits`, `equal` and `run_cnt` all hold.
- SEARCH:
  - eq=1: run_cnt←1; go to LOCKED if LOCK_COUNT=1, else COUNT.
  - eq=0: run_cnt←0; stay in SEARCH.
- COUNT:
  - eq=1: run_cnt←run_cnt+1; go to LOCKED when the new value equals LOCK_COUNT.
  - eq=0: run_cnt←0; go to SEARCH.
- LOCKED:
  - eq=1: run_cnt increments, saturating at 2^CNT_W−1 (no wrap).
  - eq=0: run_cnt←0; go to SEARCH (without the macro).
- `locked` = (state == LOCKED), or state == HOLD when the macro is defined.
- Reset mid-run: all state and outputs return to reset values on the reset edge. Any sample presented with `rst`=1 is discarded.
- Reset values: `valid_out`=0, `f`=0, `match_bits`=0, `equal`=0, `run_cnt`=0, `locked`=0, state=SEARCH.

## Timing
- Every output is a register; latency from sample to output is 1 cycle.
- A sample captured at edge n is visible after edge n, together with its `valid_out`=1.
- `locked` rises on the same edge at which `run_cnt` becomes LOCK_COUNT.
- `locked` falls on the edge that captures the breaking mismatch, or the second consecutive mismatch when the macro is defined.
- No combinational path from inputs to outputs.
- Back-to-back valid samples are accepted every cycle. Gaps with `valid`=0 do not break a run.

## Configuration
- Macro: `XNOR_LOCK_TOLERANCE_EN`.
- Defined:
  - LOCKED with eq=0 goes to HOLD; run_cnt←0; `locked` stays 1.
  - HOLD with eq=1 returns to LOCKED; run_cnt←1.
  - HOLD with eq=0 goes to SEARCH; run_cnt←0; `locked`←0.
  - A single isolated mismatch therefore does not drop lock.
- Undefined: HOLD does not exist; any mismatch in LOCKED drops to SEARCH immediately.

## Test plan
All scenarios use WIDTH=8, LOCK_COUNT=4, CNT_W=4.

- Reset then A=8'hA5, B=8'hA5 valid 4 cycles:
  - `run_cnt` goes 1,2,3,4; `locked`=1 after the 4th edge.
  - `f`=8'hFF, `match_bits`=8, `equal`=1.
- A=8'hF0, B=8'h0F, single valid sample: `f`=8'h00, `match_bits`=0, `equal`=0, `run_cnt`=0, `locked`=0.
- Three equal samples, then `valid`=0 for 5 cycles, then one equal sample:
  - Outputs hold during the gap.
  - `run_cnt`=4 and `locked`=1 after the 4th valid sample.
- Locked, then 20 equal samples: `run_cnt` saturates at 15 with no wrap and `locked` stays 1.
- Locked, then one mismatch, then one equal sample:
  - Macro undefined: `locked`=0 after the mismatch; `run_cnt`=1 after the equal sample.
  - Macro defined: `locked` stays 1 throughout; `run_cnt`=0, then 1.
  - Follow with two consecutive mismatches: `locked`=0 after the second.
- Assert `rst` on the cycle carrying the 3rd equal sample: all outputs 0 after that edge. Lock then requires 4 fresh equal samples.
